// File: rtl/uart_tx_fifo_if.sv
// CPU-side register bus of the UART transmit buffer.
// Handshake: a write takes effect on the rising clk edge where wstrb is high
// together with exactly one of sel_dat / sel_cntl; rdata is combinational from
// the select lines and is valid whenever a select is high; rstrb has no effect
// on state.
interface uart_tx_fifo_if;
    logic        wstrb;
    logic        rstrb;
    logic        sel_dat;
    logic        sel_cntl;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wstrb, rstrb, sel_dat, sel_cntl, wdata,
        input  rdata
    );

    modport slave (
        input  wstrb, rstrb, sel_dat, sel_cntl, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the CPU bus and the UART serial core. Bytes pushed by
// the CPU are queued in a circular buffer and handed to the UART one at a time
// by a small drain FSM using the core's wr/busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_fifo_if.slave      bus,
    input  logic               uart_busy_i,
    output logic               uart_wr_o,
    output logic [7:0]         uart_data_o,
    output logic               irq_empty_o,
    output logic [1:0]         state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Storage and bookkeeping
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    // Drain FSM registers
    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic                  uart_wr_q;
    logic [7:0]            uart_data_q;

    // Decoded bus actions
    logic push_req, ctrl_wr, flush, clr_ovf;
    logic full, empty, pop, push_ok;

    assign push_req = bus.sel_dat  & bus.wstrb;
    assign ctrl_wr  = bus.sel_cntl & bus.wstrb;
    assign flush    = ctrl_wr & bus.wdata[0];
    assign clr_ovf  = ctrl_wr & bus.wdata[1];

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // The head is popped in the same cycle the FSM issues it to the UART.
    assign pop     = (state_q == S_IDLE) && !empty && !uart_busy_i;
    // A pop frees a slot before the push is judged, so a full FIFO still
    // accepts a byte in a cycle where it also drains one.
    assign push_ok = push_req && (!full || pop);

    // rstrb and the upper write-data bits carry no meaning for this block.
    logic unused_bus;
    assign unused_bus = ^{bus.rstrb, bus.wdata[31:8]};

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (DEPTH_LOG2+1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (DEPTH_LOG2+1)'(1);
        end

        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        // Flush overrides any same-cycle push or pop; the FSM keeps running.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Register pointers, occupancy and overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    // Drain FSM: issue one byte, wait for busy to rise (or time out), then
    // wait for busy to fall before looking at the FIFO again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    uart_wr_q <= 1'b0;
                    if (pop) begin
                        uart_data_q <= mem_q[rd_ptr_q];
                        uart_wr_q   <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    uart_wr_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    uart_wr_q <= 1'b0;
                    if (uart_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                        // UART never acknowledged; treat the byte as sent.
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    uart_wr_q <= 1'b0;
                    if (!uart_busy_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    uart_wr_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Status / data register read mux.
    always_comb begin
        bus.rdata = '0;
        if (bus.sel_cntl) begin
            bus.rdata[12:5] = 8'(count_q);
            bus.rdata[3]    = ovf_q;
            bus.rdata[2]    = (state_q != S_IDLE) || uart_busy_i;
            bus.rdata[1]    = full;
            bus.rdata[0]    = empty;
        end else if (bus.sel_dat) begin
            bus.rdata[9] = full;
        end
    end

    assign uart_wr_o   = uart_wr_q;
    assign uart_data_o = uart_data_q;
    assign irq_empty_o = empty && (state_q == S_IDLE) && !uart_busy_i;
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: register-level vector table, directed multi-cycle
// sequences and a randomized push/drain run against a queue-based model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int BT    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_busy;
    logic       uart_wr;
    logic [7:0] uart_data;
    logic       irq_empty;
    logic [1:0] state_dbg;

    uart_tx_fifo_if bus_if();

    uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .uart_busy_i (uart_busy),
        .uart_wr_o   (uart_wr),
        .uart_data_o (uart_data),
        .irq_empty_o (irq_empty),
        .state_o     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // UART core model: busy rises the cycle after wr and holds busy_len cycles.
    int busy_left  = 0;
    int busy_len   = 10;
    bit never_busy = 1'b0;
    bit force_busy = 1'b0;
    bit rand_len   = 1'b0;

    always @(posedge clk) begin
        if (uart_wr) begin
            if (never_busy)    busy_left <= 0;
            else if (rand_len) busy_left <= int'($urandom_range(0, 6));
            else               busy_left <= busy_len;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
    end
    assign uart_busy = force_busy || (busy_left > 0);

    // Scoreboard
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         wr_cyc_q[$];
    int         wr_total = 0;
    int         cyc = 0;
    logic       prev_wr = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: collect every byte issued to the UART.
    always @(negedge clk) begin
        cyc++;
        if (uart_wr) begin
            got_q.push_back(uart_data);
            wr_cyc_q.push_back(cyc);
            wr_total++;
            check("wr_single_cycle", 32'(prev_wr), 32'd0);
        end
        prev_wr = uart_wr;
    end

    // Driver tasks
    task automatic bus_clear();
        bus_if.wstrb    = 1'b0;
        bus_if.rstrb    = 1'b0;
        bus_if.sel_dat  = 1'b0;
        bus_if.sel_cntl = 1'b0;
        bus_if.wdata    = 32'h0;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_ok);
        bus_if.sel_dat = 1'b1;
        bus_if.wstrb   = 1'b1;
        bus_if.wdata   = {24'h0, b};
        if (expect_ok) exp_q.push_back(b);
        @(negedge clk);
        bus_clear();
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        bus_if.sel_cntl = 1'b1;
        bus_if.wstrb    = 1'b1;
        bus_if.wdata    = v;
        @(negedge clk);
        bus_clear();
    endtask

    // rsel: 0 = nothing selected, 1 = data register, 2 = control register
    task automatic read_reg(input logic [1:0] rsel, output logic [31:0] v);
        bus_if.sel_dat  = (rsel == 2'd1);
        bus_if.sel_cntl = (rsel == 2'd2);
        bus_if.rstrb    = 1'b1;
        #1;
        v = bus_if.rdata;
        bus_clear();
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && !irq_empty; i++) @(negedge clk);
        check(name, 32'(irq_empty), 32'd1);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Register-level vectors, applied with the UART held busy so nothing drains.
    typedef struct {
        logic        sd;
        logic        sc;
        logic        ws;
        logic [31:0] wd;
        logic [1:0]  rsel;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;
        int          acc;
        int          base_wr;
        int          mcnt;
        logic [7:0]  b;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,  2'd2, 32'h005};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'hA1, 2'd2, 32'h024};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hA2, 2'd2, 32'h044};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hA3, 2'd1, 32'h000};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,  2'd2, 32'h064};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h1,  2'd2, 32'h005};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 32'h000};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'hB7, 2'd2, 32'h024};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h3,  2'd2, 32'h005};

        // Reset
        reset = 1'b1;
        bus_clear();
        repeat (2) @(negedge clk);
        check("rst_wr", 32'(uart_wr), 32'd0);
        check("rst_data", 32'(uart_data), 32'd0);
        check("rst_irq", 32'(irq_empty), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        read_reg(2'd2, v);
        check("rst_status", v, 32'h001);
        reset = 1'b0;
        @(negedge clk);

        // Vector table
        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_if.sel_dat  = vecs[i].sd;
            bus_if.sel_cntl = vecs[i].sc;
            bus_if.wstrb    = vecs[i].ws;
            bus_if.wdata    = vecs[i].wd;
            @(negedge clk);
            bus_clear();
            read_reg(vecs[i].rsel, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("vec_no_issue", 32'(wr_total), 32'd0);

        // Single byte: uart_wr two cycles after the push
        push(8'h41, 1'b1);
        check("t1_wr_not_yet", 32'(uart_wr), 32'd0);
        @(negedge clk);
        check("t1_wr", 32'(uart_wr), 32'd1);
        check("t1_data", 32'(uart_data), 32'h41);
        check("t1_irq_low", 32'(irq_empty), 32'd0);
        wait_idle("t1_irq_back", 60);
        compare_stream("t1");

        // Fill to 16, then drain in order
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i), 1'b1);
        read_reg(2'd2, v);
        check("t2_full_status", v, 32'h206);
        read_reg(2'd1, v);
        check("t2_dat_full", v, 32'h200);
        force_busy = 1'b0;
        wait_idle("t2_drain", 600);
        compare_stream("t2");
        read_reg(2'd2, v);
        check("t2_empty_status", v, 32'h001);

        // Overflow while stalled, then clear it
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b1);
        push(8'h55, 1'b0);
        read_reg(2'd2, v);
        check("t3_overflow", v, 32'h20E);
        ctrl_write(32'h2);
        read_reg(2'd2, v);
        check("t3_ovf_clear", v, 32'h206);
        force_busy = 1'b0;
        wait_idle("t3_drain", 600);
        compare_stream("t3");

        // Flush while stalled
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(8'h90 + i), 1'b0);
        read_reg(2'd2, v);
        check("t4_three", v, 32'h064);
        ctrl_write(32'h1);
        read_reg(2'd2, v);
        check("t4_flushed", v, 32'h005);
        n = wr_total;
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_no_wr", 32'(wr_total), 32'(n));
        check("t4_irq", 32'(irq_empty), 32'd1);

        // UART that never goes busy: timeout path, spacing ISSUE+timeout+IDLE
        never_busy = 1'b1;
        wr_cyc_q.delete();
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i), 1'b1);
        wait_idle("t5_done", 200);
        compare_stream("t5");
        if (wr_cyc_q.size() == 5) begin
            for (int i = 1; i < 5; i++)
                check($sformatf("t5_gap%0d", i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'(BT + 2));
        end else begin
            check("t5_pulses", 32'(wr_cyc_q.size()), 32'd5);
        end
        never_busy = 1'b0;

        // Reset during WAIT_DONE with 4 bytes queued
        busy_len = 10;
        push(8'h80, 1'b1);
        for (int i = 1; i < 5; i++) push(8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20 && state_dbg != 2'd3; i++) @(negedge clk);
        check("t6_in_wait_done", 32'(state_dbg), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_wr", 32'(uart_wr), 32'd0);
        check("t6_state", 32'(state_dbg), 32'd0);
        read_reg(2'd2, v);
        check("t6_status", v & 32'hFFFF_FFFB, 32'h001);
        check("t6_irq_follows_busy", 32'(irq_empty), 32'(!uart_busy));
        wait_idle("t6_irq", 30);
        repeat (10) @(negedge clk);
        compare_stream("t6");

        // Randomized pushes with random busy lengths against a queue model
        rand_len = 1'b1;
        acc      = 0;
        base_wr  = wr_total;
        for (int it = 0; it < 400; it++) begin
            #1;
            mcnt = acc - (wr_total - base_wr);
            if (mcnt < DEPTH && $urandom_range(0, 2) != 0) begin
                b = 8'($urandom);
                push(b, 1'b1);
                acc++;
            end else begin
                bus_if.sel_cntl = 1'b1;
                bus_if.rstrb    = 1'b1;
                #1;
                mcnt = acc - (wr_total - base_wr);
                v = bus_if.rdata;
                bus_clear();
                check("rand_status", v & 32'h1FEB,
                      (32'(mcnt) << 5) | ((mcnt == DEPTH) ? 32'h2 : 32'h0) |
                      ((mcnt == 0) ? 32'h1 : 32'h0));
                @(negedge clk);
            end
        end
        wait_idle("rand_drain", 800);
        compare_stream("rand");
        rand_len = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
